// File: rtl/fetch_queue.sv
// Instruction fetch stage: streams sequential 16-bit words from memory into a
// small FIFO of {word, pc} entries and hands them to decode via valid/ready.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk,
   input  logic        reset,
   output logic        mem_op,
   output logic [15:0] mem_addr,
   input  logic [15:0] mem_data,
   input  logic        mem_grant,
   input  logic        redirect,
   input  logic [15:0] redirect_pc,
   output logic        instr_valid,
   output logic [15:0] instr,
   output logic [15:0] instr_pc,
   input  logic        instr_ready
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic [15:0] word;
      logic [15:0] pc;
   } entry_t;

   entry_t          mem_q [DEPTH];
   logic [AW-1:0]   rd_q, rd_d;
   logic [AW-1:0]   wr_q, wr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     pc_q, pc_d;
   logic            full;
   logic            push;
   logic            pop;
   logic            unused_ok;

   assign unused_ok   = redirect_pc[0];

   assign full        = (cnt_q == CW'(DEPTH));
   assign instr_valid = (cnt_q != '0);
   assign pop         = instr_valid & instr_ready & ~redirect;
   // A full queue may still accept a word when the head leaves in the same cycle.
   assign push        = mem_grant & ~redirect & (~full | pop);

   assign mem_op      = 1'b0;
   assign mem_addr    = pc_q;
   assign instr       = mem_q[rd_q].word;
   assign instr_pc    = mem_q[rd_q].pc;

   always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      cnt_d = cnt_q;
      pc_d  = pc_q;
      if (redirect) begin
         rd_d  = '0;
         wr_d  = '0;
         cnt_d = '0;
         pc_d  = {redirect_pc[15:1], 1'b0};
      end else begin
         if (pop)
            rd_d = rd_q + AW'(1);
         if (push) begin
            wr_d = wr_q + AW'(1);
            pc_d = pc_q + 16'd2;
         end
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_q  <= '0;
         wr_q  <= '0;
         cnt_q <= '0;
         pc_q  <= RESET_PC;
      end else begin
         rd_q  <= rd_d;
         wr_q  <= wr_d;
         cnt_q <= cnt_d;
         pc_q  <= pc_d;
      end
   end

   // Storage is cleared on reset so the head reads as zero until the first fetch.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++)
            mem_q[i] <= '0;
      end else if (push) begin
         mem_q[wr_q] <= '{word: mem_data, pc: pc_q};
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a byte-addressed memory model feeds the DUT
// and a scoreboard of expected {word, pc} entries is checked on every pop.
module tb_fetch_queue;

   localparam int          DEPTH    = 4;
   localparam logic [15:0] RESET_PC = 16'h0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        mem_op;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        mem_grant;
   logic        redirect;
   logic [15:0] redirect_pc;
   logic        instr_valid;
   logic [15:0] instr;
   logic [15:0] instr_pc;
   logic        instr_ready;

   logic [7:0]  mem [0:65535];
   logic [15:0] addr_hi;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] m_pc;
   logic [31:0] sbq [$];

   always #5 clk = ~clk;

   assign addr_hi  = mem_addr + 16'd1;
   assign mem_data = {mem[addr_hi], mem[mem_addr]};

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk         (clk),
      .reset       (reset),
      .mem_op      (mem_op),
      .mem_addr    (mem_addr),
      .mem_data    (mem_data),
      .mem_grant   (mem_grant),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_pc    (instr_pc),
      .instr_ready (instr_ready)
   );

   function automatic logic [15:0] word_at(input logic [15:0] a);
      logic [15:0] a1;
      a1 = a + 16'd1;
      return {mem[a1], mem[a]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: check outputs mid-cycle, advance the reference model, then clock.
   task automatic cycle();
      bit          mv, pop, push;
      logic [31:0] e;
      @(negedge clk);
      chk("mem_addr", {16'h0, mem_addr}, {16'h0, m_pc});
      chk("instr_valid", {31'h0, instr_valid}, {31'h0, sbq.size() != 0});
      chk("mem_op", {31'h0, mem_op}, 32'h0);
      mv = (sbq.size() != 0);
      if (reset) begin
         sbq.delete();
         m_pc = RESET_PC;
      end else if (redirect) begin
         sbq.delete();
         m_pc = {redirect_pc[15:1], 1'b0};
      end else begin
         pop  = mv && instr_ready;
         push = mem_grant && (sbq.size() < DEPTH || pop);
         if (pop) begin
            e = sbq.pop_front();
            chk("head", {instr, instr_pc}, e);
         end
         if (push) begin
            sbq.push_back({word_at(m_pc), m_pc});
            m_pc = m_pc + 16'd2;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      for (int a = 0; a < 65536; a += 2) begin
         mem[a]     = a[7:0] ^ 8'hA5;
         mem[a + 1] = a[15:8] ^ 8'h3C;
      end
      for (int k = 0; k < 4; k++) begin
         mem[2*k]     = 8'h11 * (k + 1);
         mem[2*k + 1] = 8'h11 * (k + 1);
      end

      reset = 1'b1; mem_grant = 1'b0; redirect = 1'b0;
      redirect_pc = 16'h0; instr_ready = 1'b0;
      @(posedge clk); #1;
      m_pc = RESET_PC;
      chk("rst_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst_instr", {16'h0, instr}, 32'h0);
      chk("rst_pc", {16'h0, instr_pc}, 32'h0);
      chk("rst_addr", {16'h0, mem_addr}, {16'h0, RESET_PC});
      chk("rst_op", {31'h0, mem_op}, 32'h0);

      // Streaming from reset: valid rises the cycle after release.
      reset = 1'b0; mem_grant = 1'b1; instr_ready = 1'b1;
      cycle();
      chk("first_valid", {31'h0, instr_valid}, 32'h1);
      chk("first_instr", {16'h0, instr}, 32'h1111);
      run(6);

      // Stall until full; head and fetch address must hold.
      reset = 1'b1; cycle();
      reset = 1'b0; instr_ready = 1'b0;
      run(10);
      chk("stall_addr", {16'h0, mem_addr}, 32'h0008);
      chk("stall_instr", {16'h0, instr}, 32'h1111);
      chk("stall_pc", {16'h0, instr_pc}, 32'h0000);
      instr_ready = 1'b1;
      run(8);

      // Redirect with three entries queued and decode ready.
      reset = 1'b1; cycle();
      reset = 1'b0; instr_ready = 1'b0;
      run(3);
      redirect = 1'b1; redirect_pc = 16'h0101; instr_ready = 1'b1;
      cycle();
      redirect = 1'b0;
      chk("redir_valid", {31'h0, instr_valid}, 32'h0);
      chk("redir_addr", {16'h0, mem_addr}, 32'h0100);
      run(4);

      // Grant gaps: pushes only in granted cycles.
      redirect = 1'b1; redirect_pc = 16'h0010; cycle();
      redirect = 1'b0;
      mem_grant = 1'b1; cycle();
      mem_grant = 1'b0; cycle();
      chk("gap_addr", {16'h0, mem_addr}, 32'h0012);
      cycle();
      mem_grant = 1'b1; cycle();
      mem_grant = 1'b0; run(3);
      chk("gap_drain", {31'h0, instr_valid}, 32'h0);

      // Address wrap at the top of memory.
      redirect = 1'b1; redirect_pc = 16'hFFFC; cycle();
      redirect = 1'b0; mem_grant = 1'b1; instr_ready = 1'b0;
      run(4);
      chk("wrap_addr", {16'h0, mem_addr}, 32'h0004);
      instr_ready = 1'b1; mem_grant = 1'b0;
      run(5);

      // Full-and-push-pop in the same cycle keeps the queue full.
      mem_grant = 1'b1; instr_ready = 1'b0; run(6);
      instr_ready = 1'b1; run(3);

      // Reset while full and stalled discards everything.
      instr_ready = 1'b0; run(6);
      reset = 1'b1; cycle();
      reset = 1'b0;
      chk("rst2_valid", {31'h0, instr_valid}, 32'h0);
      chk("rst2_addr", {16'h0, mem_addr}, {16'h0, RESET_PC});
      instr_ready = 1'b1; run(4);

      // Reset takes priority over a simultaneous redirect.
      reset = 1'b1; redirect = 1'b1; redirect_pc = 16'h4000; cycle();
      reset = 1'b0; redirect = 1'b0;
      chk("rst_vs_redir", {16'h0, mem_addr}, {16'h0, RESET_PC});
      run(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
